// File: rtl/gray_up_dn_counter_if.sv
// Control and status bundle for gray_up_dn_counter.
//
// Signals
//   en        count enable, one step per clock while high
//   up_dn     direction: 1 = increment, 0 = decrement
//   load      parallel load strobe (takes priority over en)
//   load_val  binary value to load
//   gray_out  registered Gray code of the internal count
//   tc        terminal count for the current (live) direction
//   upd       one-cycle pulse: gray_out changed on the previous edge
//
// Modports
//   master  drives the controls and observes the status (user side)
//   slave   the counter itself
interface gray_up_dn_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] gray_out;
  logic             tc;
  logic             upd;

  modport master (
    output en,
    output up_dn,
    output load,
    output load_val,
    input  gray_out,
    input  tc,
    input  upd
  );

  modport slave (
    input  en,
    input  up_dn,
    input  load,
    input  load_val,
    output gray_out,
    output tc,
    output upd
  );
endinterface

// File: rtl/gray_up_dn_counter.sv
// Up/down counter held in binary and presented as registered Gray code. It feeds a downstream
// Gray-to-binary converter, so every count step changes exactly one gray_out bit (wrap included).
// Loads may change several bits at once.
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (cnt, gray_out and upd cleared)
//   bus    gray_up_dn_counter_if.slave: en, up_dn, load, load_val in; gray_out, tc, upd out
//
// Edge priority: reset > load > en. With en low and load low the count holds.
// tc is combinational from the registered count and the live up_dn input.
//
// Build option
//   GRAY_CNT_SAT_EN  when defined, stepping saturates at the top (up) and at zero (down)
//                    instead of wrapping; loads are unaffected.
module gray_up_dn_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gray_up_dn_counter_if.slave     bus
);

  localparam logic [WIDTH-1:0] MaxCnt  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZeroCnt = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] OneCnt  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             upd_q, upd_d;

  // Next binary count.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.load) begin
      cnt_d = bus.load_val;
    end else if (bus.en) begin
      if (bus.up_dn) begin
`ifdef GRAY_CNT_SAT_EN
        if (cnt_q != MaxCnt) cnt_d = cnt_q + OneCnt;
`else
        cnt_d = cnt_q + OneCnt;
`endif
      end else begin
`ifdef GRAY_CNT_SAT_EN
        if (cnt_q != ZeroCnt) cnt_d = cnt_q - OneCnt;
`else
        cnt_d = cnt_q - OneCnt;
`endif
      end
    end
  end

  // Gray code is taken from the next count so it registers on the same edge as cnt (no lag).
  always_comb begin
    gray_d = cnt_d ^ (cnt_d >> 1);
    upd_d  = (gray_d != gray_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= ZeroCnt;
      gray_q <= ZeroCnt;
      upd_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
      upd_q  <= upd_d;
    end
  end

  assign bus.gray_out = gray_q;
  assign bus.upd      = upd_q;
  assign bus.tc       = bus.up_dn ? (cnt_q == MaxCnt) : (cnt_q == ZeroCnt);

endmodule
